// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

  // Arbiter FSM: IDLE picks an owner, SERVE grants that owner's accesses.
  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Requester indices (port 0 = CPU load/store, port 1 = debug/DMA loader).
  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  // Default address/data widths.
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way round-robin selector: the port that was not served last wins a tie.
module dm_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // A lone requester wins outright; under contention the port other than 'last' wins.
  always_comb begin
    any = |req;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1] & ~req[0];
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between two requesters,
// with bounded bursts and registered per-port read data.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Wide enough to hold BURST_MAX-1 even when BURST_MAX is 1.
  localparam int CW = $clog2(BURST_MAX) + 1;

  state_t          state_reg;
  state_t          state_next;
  logic            owner_reg;
  logic            last_reg;
  logic [CW-1:0]   burst_cnt_reg;

  logic [1:0]      req_vec;
  logic [1:0]      we_vec;
  logic [1:0]      gnt_vec;
  logic            pick_winner;
  logic            pick_any;

  logic            owner_req;
  logic            owner_we;
  logic [AW-1:0]   owner_addr;
  logic [DW-1:0]   owner_wdata;
  logic            burst_end;

  logic [1:0]      rvalid_reg;
  logic [DW-1:0]   rdata_reg [2];

  assign req_vec = {m1_req, m0_req};
  assign we_vec  = {m1_we,  m0_we};

  dm_rr_pick u_pick (
    .req    (req_vec),
    .last   (last_reg),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Current owner's request fields; the other port never reaches the memory.
  assign owner_req   = owner_reg ? m1_req   : m0_req;
  assign owner_we    = owner_reg ? m1_we    : m0_we;
  assign owner_addr  = owner_reg ? m1_addr  : m0_addr;
  assign owner_wdata = owner_reg ? m1_wdata : m0_wdata;
  assign burst_end   = (burst_cnt_reg == CW'(BURST_MAX - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: leave SERVE when the owner lets go or its burst is used up.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any) state_next = SERVE;
      SERVE:   if (!owner_req || burst_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: grant and memory drive only for the owner while it is requesting.
  always_comb begin
    gnt_vec   = 2'b00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_reg == SERVE);
    if (state_reg == SERVE && owner_req) begin
      gnt_vec[owner_reg] = 1'b1;
      mem_we             = owner_we;
      mem_re             = ~owner_we;
      mem_addr           = owner_addr;
      mem_wdata          = owner_wdata;
    end
  end

  // Owner selection, round-robin history and burst length tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg     <= 1'b0;
      last_reg      <= 1'b1;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            owner_reg     <= pick_winner;
            burst_cnt_reg <= '0;
          end
        end
        SERVE: begin
          if (!owner_req || burst_end) begin
            last_reg      <= owner_reg;
            burst_cnt_reg <= '0;
          end else begin
            burst_cnt_reg <= burst_cnt_reg + CW'(1);
          end
        end
        default: burst_cnt_reg <= '0;
      endcase
    end
  end

  assign m0_gnt = gnt_vec[PORT0];
  assign m1_gnt = gnt_vec[PORT1];

  // Per-port read return: capture memory data at the granted read's edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      // One-cycle rvalid pulse; rdata holds until this port's next read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
          rdata_reg[gi]  <= '0;
        end else begin
          rvalid_reg[gi] <= gnt_vec[gi] & ~we_vec[gi];
          if (gnt_vec[gi] && !we_vec[gi]) begin
            rdata_reg[gi] <= mem_rdata;
          end
        end
      end
    end
  endgenerate

  assign m0_rvalid = rvalid_reg[PORT0];
  assign m1_rvalid = rvalid_reg[PORT1];
  assign m0_rdata  = rdata_reg[PORT0];
  assign m1_rdata  = rdata_reg[PORT1];

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench: two arbiters (bursts of 4 and of 1), each with its own
// memory, checked every cycle against a transaction-level reference model.
module tb_dm_port_arbiter;

  logic clk;
  logic rst;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        gnt   [2][2];
  logic        rvalid[2][2];
  logic [31:0] rdata [2][2];

  logic        mem_we    [2];
  logic        mem_re    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  logic [31:0] dmem [2][16];

  int n_compared;
  int n_mismatched;

  // Reference model state (per instance)
  int          bl       [2];
  bit          m_busy   [2];
  int          m_owner  [2];
  int          m_last   [2];
  int          m_cnt    [2];
  bit          m_rvalid [2][2];
  logic [31:0] m_rdata  [2][2];
  logic [31:0] rmem     [2][16];

  // Expected combinational outputs for the current cycle
  bit          eg     [2][2];
  bit          e_we   [2];
  bit          e_re   [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dm_port_arbiter #(.AW(32), .DW(32), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Data memories: combinational read, write on the clock edge.
  assign mem_rdata[0] = dmem[0][mem_addr[0][5:2]];
  assign mem_rdata[1] = dmem[1][mem_addr[1][5:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) dmem[i][k] <= 32'h0;
      end else if (mem_we[i]) begin
        dmem[i][mem_addr[i][5:2]] <= mem_wdata[i];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i]  = 1'b0;
      m_owner[i] = 0;
      m_last[i]  = 1;
      m_cnt[i]   = 0;
      for (int p = 0; p < 2; p++) begin
        m_rvalid[i][p] = 1'b0;
        m_rdata[i][p]  = 32'h0;
      end
      for (int k = 0; k < 16; k++) rmem[i][k] = 32'h0;
    end
  endtask

  task automatic compute_expect();
    for (int i = 0; i < 2; i++) begin
      int o;
      for (int p = 0; p < 2; p++) eg[i][p] = m_busy[i] && (m_owner[i] == p) && req[i][p];
      o = m_owner[i];
      e_we[i]    = eg[i][o] && we[i][o];
      e_re[i]    = eg[i][o] && !we[i][o];
      e_addr[i]  = eg[i][o] ? addr[i][o]  : 32'h0;
      e_wdata[i] = eg[i][o] ? wdata[i][o] : 32'h0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("d%0d_gnt0", i), 64'(gnt[i][0]), 64'(eg[i][0]));
      check_val($sformatf("d%0d_gnt1", i), 64'(gnt[i][1]), 64'(eg[i][1]));
      check_val($sformatf("d%0d_mem_we", i), 64'(mem_we[i]), 64'(e_we[i]));
      check_val($sformatf("d%0d_mem_re", i), 64'(mem_re[i]), 64'(e_re[i]));
      check_val($sformatf("d%0d_mem_addr", i), 64'(mem_addr[i]), 64'(e_addr[i]));
      check_val($sformatf("d%0d_mem_wdata", i), 64'(mem_wdata[i]), 64'(e_wdata[i]));
      check_val($sformatf("d%0d_busy", i), 64'(busy[i]), 64'(m_busy[i]));
      for (int p = 0; p < 2; p++) begin
        check_val($sformatf("d%0d_rvalid%0d", i, p), 64'(rvalid[i][p]), 64'(m_rvalid[i][p]));
        check_val($sformatf("d%0d_rdata%0d", i, p), 64'(rdata[i][p]), 64'(m_rdata[i][p]));
      end
    end
  endtask

  // Advance the reference by one clock edge using this cycle's inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        m_rvalid[i][p] = eg[i][p] && !we[i][p];
        if (eg[i][p]) begin
          if (we[i][p]) rmem[i][addr[i][p][5:2]] = wdata[i][p];
          else          m_rdata[i][p] = rmem[i][addr[i][p][5:2]];
          $display("[%0t] dut%0d port%0d %s addr=%h data=%h", $time, i, p,
                   we[i][p] ? "WR" : "RD", addr[i][p],
                   we[i][p] ? wdata[i][p] : m_rdata[i][p]);
        end
      end
      if (!m_busy[i]) begin
        if (req[i][0] || req[i][1]) begin
          if (req[i][0] && req[i][1]) m_owner[i] = (m_last[i] == 0) ? 1 : 0;
          else                        m_owner[i] = req[i][1] ? 1 : 0;
          m_busy[i] = 1'b1;
          m_cnt[i]  = 0;
        end
      end else if (!req[i][m_owner[i]]) begin
        m_busy[i] = 1'b0;
        m_last[i] = m_owner[i];
        m_cnt[i]  = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == bl[i]) begin
          m_busy[i] = 1'b0;
          m_last[i] = m_owner[i];
          m_cnt[i]  = 0;
        end
      end
    end
  endtask

  task automatic new_request(input int i, input int p);
    req[i][p]   = 1'b1;
    we[i][p]    = $urandom_range(0, 1) == 1;
    addr[i][p]  = $urandom;
    wdata[i][p] = $urandom;
  endtask

  // Requesters hold fields until granted; they may also abandon a pending request.
  task automatic drive_inputs(input int rate);
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (req[i][p] && eg[i][p]) begin
          if ($urandom_range(0, 99) < rate) new_request(i, p);
          else req[i][p] = 1'b0;
        end else if (req[i][p]) begin
          if ($urandom_range(0, 19) == 0) req[i][p] = 1'b0;
        end else if ($urandom_range(0, 99) < rate) begin
          new_request(i, p);
        end
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    bl[0] = 4;
    bl[1] = 1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = 32'h0; wdata[i][p] = 32'h0;
      end
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    compute_expect();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      drive_inputs(((cyc / 200) % 2 == 1) ? 95 : 45);
      #1;
      if (cyc % 600 == 300) begin
        // Asynchronous reset in the middle of a cycle must silence everything at once.
        rst = 1'b1;
        #1;
        model_reset();
      end
      compute_expect();
      check_all();
      @(posedge clk);
      if (!rst) model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
